// File: rtl/subcarrier_ctrl_pkg.sv
// Shared state encoding and default constants for the subcarrier controller.
// The preamble phase is built only when SC_PREAMBLE_EN is defined.
package subcarrier_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_DRAIN    = 2'd3
    } sc_state_t;

    localparam int DEF_DIV_W            = 8;
    localparam int DEF_BIT_HALFCYC      = 16;
    localparam int DEF_PREAMBLE_HALFCYC = 32;
    localparam int DRAIN_HALFCYC        = 2;

    // Width of a counter that has to reach (longest phase length - 1) ticks.
    function automatic int phase_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (DRAIN_HALFCYC > m) m = DRAIN_HALFCYC;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/subcarrier_ctrl_tick_gen.sv
// Half-period divider: counts 0..half_div-1, pulses tick on the last count and
// toggles the raw subcarrier. clear holds counter and sc_raw at zero.
module sc_tick_gen
    import subcarrier_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] half_div,
    output logic             tick,
    output logic             sc_raw
);

    logic [DIV_W-1:0] counter;

    assign tick = (counter == (half_div - DIV_W'(1)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            sc_raw  <= 1'b0;
        end else if (clear) begin
            counter <= '0;
            sc_raw  <= 1'b0;
        end else if (tick) begin
            counter <= '0;
            sc_raw  <= ~sc_raw;
        end else begin
            counter <= counter + DIV_W'(1);
        end
    end

endmodule

// File: rtl/subcarrier_ctrl.sv
// Subcarrier modulator: preamble (SC_PREAMBLE_EN only), data slots phase-flipped
// for '1' bits, then a short drain. Bits arrive through a one-entry holding register.
module subcarrier_ctrl
    import subcarrier_ctrl_pkg::*;
#(
    parameter int DIV_W            = DEF_DIV_W,
    parameter int BIT_HALFCYC      = DEF_BIT_HALFCYC,
    parameter int PREAMBLE_HALFCYC = DEF_PREAMBLE_HALFCYC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             bit_data,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             sc_out,
    output logic             busy,
    output logic             done
);

    localparam int SLOT_W = phase_cnt_w(PREAMBLE_HALFCYC, BIT_HALFCYC);
    localparam logic [SLOT_W-1:0] BIT_LAST   = SLOT_W'(BIT_HALFCYC - 1);
    localparam logic [SLOT_W-1:0] DRAIN_LAST = SLOT_W'(DRAIN_HALFCYC - 1);
`ifdef SC_PREAMBLE_EN
    localparam logic [SLOT_W-1:0] PRE_LAST   = SLOT_W'(PREAMBLE_HALFCYC - 1);
`endif

    sc_state_t         state;
    sc_state_t         state_next;
    logic [DIV_W-1:0]  half_div;
    logic [SLOT_W-1:0] slot_cnt;
    logic              hold_bit;
    logic              hold_full;
    logic              cur_bit;
    logic              tick;
    logic              sc_raw;
    logic              gen_clear;
    logic              transfer;
    logic              load;
    logic              phase_end;

    // Valid/ready: a bit moves into the holding register on any rising edge where
    // bit_valid and bit_ready are both high; bit_ready never depends on bit_valid.
    assign busy      = (state != ST_IDLE);
    assign bit_ready = busy & ~hold_full & (state != ST_DRAIN);
    assign transfer  = bit_valid & bit_ready;

    // Also clear on the way out so the divider is already zero in the first IDLE cycle.
    assign gen_clear = (state == ST_IDLE) | (state_next == ST_IDLE);

    sc_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clock    (clock),
        .reset    (reset),
        .clear    (gen_clear),
        .half_div (half_div),
        .tick     (tick),
        .sc_raw   (sc_raw)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        phase_end  = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
`ifdef SC_PREAMBLE_EN
                    state_next = ST_PREAMBLE;
`else
                    state_next = ST_ACTIVE;
`endif
                end
            end
`ifdef SC_PREAMBLE_EN
            ST_PREAMBLE: begin
                if (tick && slot_cnt == PRE_LAST) begin
                    phase_end  = 1'b1;
                    load       = hold_full;
                    state_next = hold_full ? ST_ACTIVE : ST_DRAIN;
                end
            end
`endif
            // Without a preamble the first ACTIVE slot carries cur_bit = 0, since no
            // bit can be held yet; data loading starts at its closing boundary.
            ST_ACTIVE: begin
                if (tick && slot_cnt == BIT_LAST) begin
                    phase_end  = 1'b1;
                    load       = hold_full;
                    state_next = hold_full ? ST_ACTIVE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tick && slot_cnt == DRAIN_LAST) begin
                    phase_end  = 1'b1;
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            half_div <= '0;
        end else if (state == ST_IDLE && start) begin
            half_div <= (div_sel == '0) ? DIV_W'(1) : div_sel;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_cnt <= '0;
        end else if (state == ST_IDLE || phase_end) begin
            slot_cnt <= '0;
        end else if (tick) begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // A load and a new transfer in one cycle keep the entry full with the new bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_bit  <= 1'b0;
            hold_full <= 1'b0;
            cur_bit   <= 1'b0;
        end else begin
            if (state == ST_IDLE) cur_bit <= 1'b0;
            else if (load)        cur_bit <= hold_bit;

            if (transfer) begin
                hold_bit  <= bit_data;
                hold_full <= 1'b1;
            end else if (load || state == ST_IDLE) begin
                hold_full <= 1'b0;
            end
        end
    end

    always_comb begin
        sc_out = 1'b0;
        case (state)
            ST_ACTIVE:   sc_out = sc_raw ^ cur_bit;
            ST_PREAMBLE: sc_out = sc_raw;
            ST_DRAIN:    sc_out = sc_raw;
            default:     sc_out = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_subcarrier_ctrl.sv
// Bench for subcarrier_ctrl: expected waveform built from half-period arithmetic
// (lead, data slots, drain) and compared cycle by cycle.
module tb_subcarrier_ctrl;

    localparam int DIV_W    = 8;
    localparam int BIT_HC   = 16;
    localparam int PRE_HC   = 32;
    localparam int DRAIN_HC = 2;
`ifdef SC_PREAMBLE_EN
    localparam int LEAD_HC  = PRE_HC;
`else
    localparam int LEAD_HC  = BIT_HC;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [DIV_W-1:0] div_sel;
    logic             bit_data;
    logic             bit_valid;
    logic             bit_ready;
    logic             sc_out;
    logic             busy;
    logic             done;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [2:0] exp_q[$];
    logic       frame_bits[$];

    subcarrier_ctrl #(
        .DIV_W            (DIV_W),
        .BIT_HALFCYC      (BIT_HC),
        .PREAMBLE_HALFCYC (PRE_HC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .div_sel   (div_sel),
        .bit_data  (bit_data),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .sc_out    (sc_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected {busy, done, sc_out} per cycle after start: half-period p = t / h,
    // raw subcarrier = p mod 2, inverted during slots that carry a '1'.
    task automatic build_expected(input int h);
        int total_hc;
        int total;
        int p;
        logic b;
        total_hc = LEAD_HC + frame_bits.size() * BIT_HC + DRAIN_HC;
        total    = total_hc * h;
        exp_q.delete();
        for (int t = 0; t < total; t++) begin
            p = t / h;
            b = 1'b0;
            if (p >= LEAD_HC && p < LEAD_HC + frame_bits.size() * BIT_HC)
                b = frame_bits[(p - LEAD_HC) / BIT_HC];
            exp_q.push_back({1'b1, (t == total - 1), ((p % 2) == 1) ^ b});
        end
    endtask

    task automatic random_bits(input int n);
        frame_bits.delete();
        for (int i = 0; i < n; i++) frame_bits.push_back(1'($urandom_range(0, 1)));
    endtask

    // Runs one frame; restart_at >= 0 pulses start mid-frame, abort_at >= 0 resets there.
    task automatic run_frame(input int dsel, input int restart_at, input int abort_at);
        int h;
        int next_bit;
        int delay;
        int t;
        logic [2:0] exp;
        h = (dsel == 0) ? 1 : dsel;
        build_expected(h);
        next_bit = 0;
        t = 0;
        @(negedge clock);
        div_sel   = DIV_W'(dsel);
        start     = 1'b1;
        bit_valid = 1'b0;
        delay     = $urandom_range(0, 3);
        while (exp_q.size() > 0) begin
            @(negedge clock);
            start   = 1'b0;
            div_sel = DIV_W'($urandom);
            exp = exp_q.pop_front();
            check($sformatf("frame div=%0d t=%0d {busy,done,sc_out}", dsel, t),
                  {busy, done, sc_out}, exp);
            if (t == 0) check("bit_ready_after_start", bit_ready, 1);
            if (t == restart_at) start = 1'b1;
            if (t == abort_at) begin
                bit_valid = 1'b0;
                start     = 1'b0;
                #2 reset = 1'b0;
                #1 check("async_reset_outputs", {sc_out, busy, done, bit_ready}, 0);
                repeat (3) begin
                    @(negedge clock);
                    check("in_reset_no_done", {busy, done}, 0);
                end
                reset = 1'b1;
                repeat (3) begin
                    @(negedge clock);
                    check("after_reset_idle", {sc_out, busy, done, bit_ready}, 0);
                end
                exp_q.delete();
                return;
            end
            if (next_bit < frame_bits.size()) begin
                if (delay > 0) begin
                    delay--;
                    bit_valid = 1'b0;
                end else begin
                    bit_valid = 1'b1;
                    bit_data  = frame_bits[next_bit];
                    if (bit_ready) begin
                        next_bit++;
                        delay = $urandom_range(0, 3);
                    end
                end
            end else begin
                bit_valid = 1'b0;
            end
            t++;
        end
        @(negedge clock);
        check("post_frame_idle", {sc_out, busy, done, bit_ready}, 0);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        div_sel   = '0;
        bit_data  = 1'b0;
        bit_valid = 1'b0;

        // Reset held for 3 cycles, then 100 idle cycles with no start.
        repeat (3) begin
            @(negedge clock);
            check("reset_state", {sc_out, busy, done, bit_ready}, 0);
        end
        reset = 1'b1;
        repeat (100) begin
            @(negedge clock);
            check("idle_no_start", {sc_out, busy, done, bit_ready}, 0);
        end

        // Lead-in at div 4.
        random_bits(3);
        run_frame(4, -1, -1);

        // Bits 1,0,1 at div 2.
        frame_bits.delete();
        frame_bits.push_back(1'b1);
        frame_bits.push_back(1'b0);
        frame_bits.push_back(1'b1);
        run_frame(2, -1, -1);

        // div_sel = 0 behaves as 1; start while busy is ignored.
        random_bits(2);
        run_frame(0, -1, -1);
        random_bits(2);
        run_frame(3, 40, -1);

        // Eight back-to-back bits through the holding register.
        random_bits(8);
        run_frame($urandom_range(1, 3), -1, -1);

        // Reset mid-ACTIVE, then a full normal frame.
        random_bits(6);
        run_frame(1, -1, 50);
        random_bits(4);
        run_frame(2, -1, -1);

        // Randomized frames.
        for (int k = 0; k < 4; k++) begin
            random_bits($urandom_range(1, 6));
            run_frame($urandom_range(0, 5), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
